// File: rtl/ling_seq_pkg.sv
// ---------------------------------------------------------------------------
// ling_seq_pkg
//   Shared types for the multi-limb Ling adder sequencer.
//   - LIMB_W  : limb width, fixed by the 14-bit Ling/Knowles adder core
//   - state_t : operation-tracking FSM states
//   - s1_t    : stage-1 payload (registered operand limb)
//   - s2_t    : stage-2 payload (registered result limb)
// ---------------------------------------------------------------------------
package ling_seq_pkg;

  localparam int LIMB_W = 14;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // seed marks a limb that starts a carry chain (cin comes from op_sub)
  typedef struct packed {
    logic [LIMB_W-1:0] a;
    logic [LIMB_W-1:0] b;
    logic              first;
    logic              last;
    logic              seed;
  } s1_t;

  typedef struct packed {
    logic [LIMB_W-1:0] sum;
    logic              first;
    logic              last;
    logic              cout;
    logic              ovf;
  } s2_t;

endpackage

// File: rtl/ling_limb_seq_adder.sv
// ---------------------------------------------------------------------------
// adder
//   14-bit Ling adder with a Knowles (fanout-1, Kogge-Stone style) prefix
//   tree on the Ling pseudo-carries.
//   Ports:
//     a, b  in  LIMB_W  operands
//     cin   in  1       carry in
//     sum   out LIMB_W  a + b + cin (low LIMB_W bits)
//     cout  out 1       carry out of the MS bit
// ---------------------------------------------------------------------------
module adder
  import ling_seq_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  logic [LIMB_W-1:0] g;
  logic [LIMB_W-1:0] t;
  logic [LIMB_W-1:0] x;
  logic [LIMB_W-1:0] h;
  logic [LIMB_W-1:0] c;

  assign g = a & b;
  assign t = a | b;
  assign x = a ^ b;

  // Ling pseudo-carry: h[i] = g[i] | t[i-1] & h[i-1], with h[0] = g[0] | cin.
  // The real carry is recovered afterwards as c[i] = t[i] & h[i].
  always_comb begin
    logic [LIMB_W-1:0] hg;
    logic [LIMB_W-1:0] hp;
    logic [LIMB_W-1:0] hg_n;
    logic [LIMB_W-1:0] hp_n;
    hg    = g;
    hg[0] = g[0] | cin;
    hp    = {t[LIMB_W-2:0], 1'b0};
    for (int d = 1; d < LIMB_W; d = d * 2) begin
      hg_n = hg;
      hp_n = hp;
      for (int i = d; i < LIMB_W; i++) begin
        hg_n[i] = hg[i] | (hp[i] & hg[i-d]);
        hp_n[i] = hp[i] & hp[i-d];
      end
      hg = hg_n;
      hp = hp_n;
    end
    h = hg;
  end

  assign c    = t & h;
  assign sum  = x ^ {c[LIMB_W-2:0], cin};
  assign cout = c[LIMB_W-1];

endmodule

// File: rtl/ling_limb_seq.sv
// ---------------------------------------------------------------------------
// ling_limb_seq
//   Streams multi-limb add/subtract operations (LS limb first) through the
//   14-bit Ling adder, chaining the carry between limbs. Two-stage
//   valid/ready pipeline: S1 holds operands, adder is combinational from S1,
//   S2 is the output register.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     in_valid/in_ready         input limb handshake
//     in_a, in_b                operand limbs
//     in_first, in_last, in_sub operation framing and A-B select
//     out_valid/out_ready       output limb handshake
//     out_sum                   result limb
//     out_first, out_last       framing copied from the input limb
//     out_cout                  adder carry out (0 on subtract = borrow)
//     out_ovf                   signed overflow of the operation, on last limb
//     proto_err                 sticky framing-error flag
// ---------------------------------------------------------------------------
module ling_limb_seq
  import ling_seq_pkg::*;
#(
  parameter int LIMB_W    = 14,
  parameter int MAX_LIMBS = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] in_a,
  input  logic [LIMB_W-1:0] in_b,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_sum,
  output logic              out_first,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              proto_err
);

  if (LIMB_W != ling_seq_pkg::LIMB_W) begin : g_bad_limb_w
    $error("ling_limb_seq: LIMB_W must equal the adder width (14)");
  end
  if (MAX_LIMBS < 1 || (2 ** CNT_W) <= MAX_LIMBS) begin : g_bad_cnt_w
    $error("ling_limb_seq: need MAX_LIMBS >= 1 and 2**CNT_W > MAX_LIMBS");
  end

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(MAX_LIMBS)) return CNT_W'(MAX_LIMBS);
    return c + CNT_W'(1);
  endfunction

  function automatic logic signed_ovf(input logic signed [LIMB_W-1:0] a,
                                      input logic signed [LIMB_W-1:0] b,
                                      input logic signed [LIMB_W-1:0] s);
    return (a[LIMB_W-1] == b[LIMB_W-1]) && (s[LIMB_W-1] != a[LIMB_W-1]);
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              seed;
  logic              err_set;
  logic              op_sub;
  logic              carry_q;

  logic              accept;
  logic              adv_p1;
  logic              adv_p2;
  logic              vld_p1;
  logic              vld_p2;
  s1_t               pay_p1;
  s2_t               pay_p2;
  s2_t               res_p1;

  logic [LIMB_W-1:0] add_b;
  logic [LIMB_W-1:0] add_sum;
  logic              add_cin;
  logic              add_cout;

  assign adv_p2   = !vld_p2 | out_ready;
  assign adv_p1   = vld_p1 & adv_p2;
  assign in_ready = !vld_p1 | adv_p2;
  assign accept   = in_valid & in_ready;

  // Operation framing FSM; only moves on an accepted limb. In IDLE every
  // limb starts a chain even without in_first, so a dropped first flag
  // still yields a correctly seeded carry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    seed      = 1'b0;
    err_set   = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          seed      = 1'b1;
          err_set   = !in_first;
          cnt_nxt   = CNT_W'(1);
          state_nxt = in_last ? IDLE : BUSY;
        end
        BUSY: begin
          if (in_first) begin
            seed    = 1'b1;
            err_set = 1'b1;
            cnt_nxt = CNT_W'(1);
          end else begin
            cnt_nxt = cnt_sat_inc(cnt);
          end
          state_nxt = in_last ? IDLE : BUSY;
        end
        default: state_nxt = IDLE;
      endcase
      if (!in_last && cnt_nxt == CNT_W'(MAX_LIMBS)) err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_sub    <= 1'b0;
      carry_q   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (seed)    op_sub    <= in_sub;
      if (err_set) proto_err <= 1'b1;
      if (adv_p1)  carry_q   <= add_cout;
    end
  end

  // ---- Stage 1: operand register ----
  // S1 always holds the most recently accepted limb, so op_sub (updated at
  // the same edge) always belongs to the operation S1 is working on.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (adv_p1) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pay_p1 <= '{a: in_a, b: in_b, first: in_first, last: in_last, seed: seed};
    end
  end

  assign add_b   = op_sub ? ~pay_p1.b : pay_p1.b;
  assign add_cin = pay_p1.seed ? op_sub : carry_q;

  adder u_adder (
    .a    (pay_p1.a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    res_p1       = '0;
    res_p1.sum   = add_sum;
    res_p1.first = pay_p1.first;
    res_p1.last  = pay_p1.last;
    res_p1.cout  = add_cout;
    res_p1.ovf   = pay_p1.last & signed_ovf(pay_p1.a, add_b, add_sum);
  end

  // ---- Stage 2: output register ----
  // Outputs read as 0 out of reset, so the payload is cleared with valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      pay_p2 <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) pay_p2 <= res_p1;
    end
  end

  assign out_valid = vld_p2;
  assign out_sum   = pay_p2.sum;
  assign out_first = pay_p2.first;
  assign out_last  = pay_p2.last;
  assign out_cout  = pay_p2.cout;
  assign out_ovf   = pay_p2.ovf;

endmodule

// File: tb/tb_ling_limb_seq.sv
// ---------------------------------------------------------------------------
// tb_ling_limb_seq
//   Directed and randomized checks of the multi-limb adder sequencer. Random
//   operations are predicted from whole-operand integer arithmetic.
// ---------------------------------------------------------------------------
module tb_ling_limb_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] in_a = '0;
  logic [13:0] in_b = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [13:0] out_sum;
  logic        out_first;
  logic        out_last;
  logic        out_cout;
  logic        out_ovf;
  logic        proto_err;

  always #5 clk = ~clk;

  ling_limb_seq #(.LIMB_W(14), .MAX_LIMBS(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_first(out_first), .out_last(out_last),
    .out_cout(out_cout), .out_ovf(out_ovf),
    .proto_err(proto_err)
  );

  typedef struct {
    logic [13:0] sum;
    logic        first;
    logic        last;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          out_cyc[$];
  int          acc_cyc[$];
  int          cyc = 0;
  int          n_acc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [13:0] ma[0:15];
  logic [13:0] mb[0:15];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Output scoreboard; handshake signals are stable around the negedge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      n_acc++;
      acc_cyc.push_back(cyc);
    end
    if (!rst && out_valid && out_ready) begin
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_sum", out_sum, e.sum);
        chk("out_first", out_first, e.first);
        chk("out_last", out_last, e.last);
        chk("out_ovf", out_ovf, e.ovf);
        if (e.last) chk("out_cout", out_cout, e.cout);
      end
    end
  end

  task automatic push_exp(input logic [13:0] s, input logic f, input logic l,
                          input logic c, input logic o);
    exp_t e;
    e.sum = s; e.first = f; e.last = l; e.cout = c; e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the limb is taken.
  task automatic send_limb(input logic [13:0] a, input logic [13:0] b,
                           input logic first, input logic last, input logic sub);
    bit got = 1'b0;
    in_a = a; in_b = b; in_first = first; in_last = last; in_sub = sub;
    in_valid = 1'b1;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Whole-operand reference: n limbs form W=14n-bit integers A and B.
  task automatic model_op(input int n, input logic sub);
    logic [63:0] av, bv, rv, mask;
    logic        sa, sbb, sr, co, ov;
    int          wt;
    av = '0; bv = '0;
    for (int i = 0; i < n; i++) begin
      av = av | (64'(ma[i]) << (14 * i));
      bv = bv | (64'(mb[i]) << (14 * i));
    end
    wt   = 14 * n;
    mask = (64'd1 << wt) - 64'd1;
    if (sub) begin
      rv = (av - bv) & mask;
      co = (av >= bv);
    end else begin
      rv = av + bv;
      co = rv[wt];
      rv = rv & mask;
    end
    sa = av[wt-1]; sbb = bv[wt-1]; sr = rv[wt-1];
    ov = sub ? ((sa != sbb) && (sr != sa)) : ((sa == sbb) && (sr != sa));
    for (int i = 0; i < n; i++)
      push_exp(rv[14*i +: 14], i == 0, i == n - 1, (i == n - 1) ? co : 1'b0,
               (i == n - 1) ? ov : 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic sb;
    bit   done;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 28-bit add, latency and back-to-back timing
    acc_cyc.delete(); out_cyc.delete();
    push_exp(14'h0000, 1, 0, 0, 0);
    push_exp(14'h0002, 0, 1, 0, 0);
    send_limb(14'h3FFF, 14'h0001, 1, 0, 0);
    send_limb(14'h0001, 14'h0000, 0, 1, 0);
    drain();
    if (out_cyc.size() >= 2 && acc_cyc.size() >= 1) begin
      chk("latency", out_cyc[0] - acc_cyc[0], 2);
      chk("out_gap", out_cyc[1] - out_cyc[0], 1);
    end else begin
      chk("timing_samples", out_cyc.size(), 2);
    end

    // Single-limb subtract with borrow
    push_exp(14'h3FFE, 1, 1, 0, 0);
    send_limb(14'h0005, 14'h0007, 1, 1, 1);
    drain();

    // Signed overflow
    push_exp(14'h2000, 1, 1, 0, 1);
    send_limb(14'h1FFF, 14'h0001, 1, 1, 0);
    drain();

    // Backpressure: two limbs buffered, output held, chain intact on release
    push_exp(14'h0000, 1, 0, 0, 0);
    push_exp(14'h0001, 0, 0, 0, 0);
    push_exp(14'h0001, 0, 0, 0, 0);
    push_exp(14'h0001, 0, 1, 1, 0);
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_limb(14'h3FFF, 14'h0001, i == 0, i == 3, 0);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #1;
          if (k >= 2) begin
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_sum", out_sum, 14'h0000);
            chk("stall_in_ready", in_ready, 0);
          end
        end
        chk("bp_accepts", n_acc, 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("proto_err_clean", proto_err, 0);

    // Non-first limb in IDLE: treated as first (cin = op_sub)
    push_exp(14'h0002, 0, 1, 1, 0);
    send_limb(14'h0005, 14'h0003, 0, 1, 1);
    drain();
    chk("proto_err_idle", proto_err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("proto_err_sticky", proto_err, 1);

    // First limb mid-operation: restart seeds cin from the new op_sub
    do_reset();
    chk("proto_err_rst", proto_err, 0);
    push_exp(14'h0000, 1, 0, 0, 0);
    push_exp(14'h0002, 1, 1, 1, 0);
    send_limb(14'h0000, 14'h0000, 1, 0, 0);
    send_limb(14'h0005, 14'h0003, 1, 1, 1);
    drain();
    chk("proto_err_restart", proto_err, 1);

    // Reset mid-operation drops the in-flight limb
    do_reset();
    out_ready = 1'b0;
    send_limb(14'h3FFF, 14'h0001, 1, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    exp_q.delete();
    out_ready = 1'b1;
    push_exp(14'h0030, 1, 1, 0, 0);
    send_limb(14'h0010, 14'h0020, 1, 1, 0);
    drain();

    // Random well-formed operations with random output backpressure
    done = 1'b0;
    fork
      begin
        for (int op = 0; op < 25; op++) begin
          n  = $urandom_range(1, 4);
          sb = 1'($urandom_range(0, 1));
          for (int i = 0; i < n; i++) begin
            ma[i] = ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom);
            mb[i] = ($urandom_range(0, 3) == 0) ? 14'h0000 : 14'($urandom);
          end
          model_op(n, sb);
          for (int i = 0; i < n; i++) send_limb(ma[i], mb[i], i == 0, i == n - 1, sb);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("proto_err_random", proto_err, 0);

    // Limb-count limit: MAX_LIMBS limbs is fine, one more flags an error
    do_reset();
    for (int i = 0; i < 16; i++) push_exp(14'h0000, i == 0, i == 15, 0, 0);
    for (int i = 0; i < 16; i++) send_limb(14'h0000, 14'h0000, i == 0, i == 15, 0);
    drain();
    chk("proto_err_max_ok", proto_err, 0);
    for (int i = 0; i < 17; i++) push_exp(14'h0000, i == 0, i == 16, 0, 0);
    for (int i = 0; i < 17; i++) send_limb(14'h0000, 14'h0000, i == 0, i == 16, 0);
    drain();
    chk("proto_err_max_over", proto_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
